// File: rtl/gf2_enc_pkg.sv
// Shared definitions for the quasi-cyclic GF(2) encoder datapath:
// rotation direction codes, circulant row rotation and beat-count sizing.
package gf2_enc_pkg;

  localparam bit ROT_LEFT  = 1'b0;
  localparam bit ROT_RIGHT = 1'b1;
  localparam int ROW_MAX   = 64;

  function automatic int beat_cnt_w(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

  // Rotates the low w bits of row by one place; bits at and above w come back zero.
  function automatic logic [ROW_MAX-1:0] gf2_rot1(input logic [ROW_MAX-1:0] row,
                                                  input int w, input bit dir);
    logic [ROW_MAX-1:0] mask;
    logic [ROW_MAX-1:0] r;
    mask = (w >= ROW_MAX) ? '1 : ((ROW_MAX'(1) << w) - ROW_MAX'(1));
    r    = row & mask;
    if (dir == ROT_LEFT) return ((r << 1) | (r >> (w - 1))) & mask;
    else                 return (r >> 1) | ((r & ROW_MAX'(1)) << (w - 1));
  endfunction

endpackage

// File: rtl/gf2_row_mac.sv
// Combinational W-lane GF(2) multiply-accumulate: nxt = base ^ (si & row).
module gf2_row_mac #(
  parameter int W = 8
) (
  input  logic [W-1:0] base,
  input  logic         si,
  input  logic [W-1:0] row,
  output logic [W-1:0] nxt
);

  for (genvar i = 0; i < W; i++) begin : g_lane
    assign nxt[i] = base[i] ^ (si & row[i]);
  end

endmodule

// File: rtl/gf2_qc_mac_stage.sv
// Sequential GF(2) MAC stage: folds one message bit per beat into a parity
// accumulator and emits the parity word per frame through a one-entry buffer.
module gf2_qc_mac_stage
  import gf2_enc_pkg::*;
#(
  parameter int W         = 8,
  parameter int MAX_BEATS = 64,
  parameter int ROT_DIR   = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_si,
  input  logic                                in_load,
  input  logic [W-1:0]                        in_row,
  input  logic [W-1:0]                        in_seed,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [W-1:0]                        out_parity,
  output logic [beat_cnt_w(MAX_BEATS)-1:0]    out_beats,
  output logic                                err
);

  localparam int CW = beat_cnt_w(MAX_BEATS);

  logic [W-1:0]  acc, row_q, rot, eff, base, nxt;
  logic [CW-1:0] cnt, cnt_n;
  logic          first, fire, hit_max, term;

  assign in_ready = !out_valid | out_ready;
  assign fire     = in_valid & in_ready;

  assign rot  = W'(gf2_rot1(ROW_MAX'(row_q), W, ROT_DIR != 0));
  assign eff  = in_load ? in_row : rot;
  assign base = first ? in_seed : acc;

  gf2_row_mac #(.W(W)) u_mac (
    .base (base),
    .si   (in_si),
    .row  (eff),
    .nxt  (nxt)
  );

  assign cnt_n   = (first ? CW'(0) : cnt) + CW'(1);
  assign hit_max = (cnt_n == CW'(MAX_BEATS));
  assign term    = in_last | hit_max;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_parity <= '0;
      out_beats  <= '0;
      err        <= 1'b0;
      acc        <= '0;
      row_q      <= '0;
      cnt        <= '0;
      first      <= 1'b1;
    end else begin
      // A drained word is cleared unless a terminal beat refills it this cycle.
      if (out_valid && out_ready && !(fire && term))
        out_valid <= 1'b0;
      if (fire) begin
        row_q <= eff;
        if (term) begin
          out_parity <= nxt;
          out_beats  <= cnt_n;
          out_valid  <= 1'b1;
          first      <= 1'b1;
          if (hit_max && !in_last) err <= 1'b1;
        end else begin
          acc   <= nxt;
          cnt   <= cnt_n;
          first <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_gf2_qc_mac_stage.sv
// Bench for gf2_qc_mac_stage: three instances (rotate-left, rotate-right,
// MAX_BEATS=4) share one stimulus stream; a GF(2) matrix-vector model scores them.
module tb_gf2_qc_mac_stage;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_si, in_load, in_last, out_ready;
  logic [7:0] in_row, in_seed;

  logic       ir0, ir1, ir2, ov0, ov1, ov2, er0, er1, er2;
  logic [7:0] op0, op1, op2;
  logic [6:0] ob0, ob1;
  logic [2:0] ob2;

  always #5 clk = ~clk;

  gf2_qc_mac_stage #(.W(8), .MAX_BEATS(64), .ROT_DIR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .in_si(in_si),
    .in_load(in_load), .in_row(in_row), .in_seed(in_seed), .in_last(in_last),
    .out_valid(ov0), .out_ready(out_ready), .out_parity(op0), .out_beats(ob0), .err(er0));
  gf2_qc_mac_stage #(.W(8), .MAX_BEATS(64), .ROT_DIR(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_si(in_si),
    .in_load(in_load), .in_row(in_row), .in_seed(in_seed), .in_last(in_last),
    .out_valid(ov1), .out_ready(out_ready), .out_parity(op1), .out_beats(ob1), .err(er1));
  gf2_qc_mac_stage #(.W(8), .MAX_BEATS(4), .ROT_DIR(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .in_si(in_si),
    .in_load(in_load), .in_row(in_row), .in_seed(in_seed), .in_last(in_last),
    .out_valid(ov2), .out_ready(out_ready), .out_parity(op2), .out_beats(ob2), .err(er2));

  logic       ov[3], er[3], ir[3];
  logic [7:0] op[3], ob[3];
  always_comb begin
    ov[0] = ov0; ov[1] = ov1; ov[2] = ov2;
    er[0] = er0; er[1] = er1; er[2] = er2;
    ir[0] = ir0; ir[1] = ir1; ir[2] = ir2;
    op[0] = op0; op[1] = op1; op[2] = op2;
    ob[0] = {1'b0, ob0}; ob[1] = {1'b0, ob1}; ob[2] = {5'b0, ob2};
  end

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;
  bit rnd_rdy = 0;

  // Reference model: per instance, the generator rows and message bits of the
  // current frame; parity is seed + G^T * u over GF(2) at frame end.
  int         maxb[3] = '{64, 64, 4};
  bit         rdir[3] = '{1'b0, 1'b1, 1'b0};
  bit [7:0]   m_row[3];
  bit [7:0]   m_seed[3];
  bit [7:0]   m_g[3][64];
  bit         m_u[3][64];
  int         m_cnt[3];
  bit         m_first[3];
  bit         m_err[3];
  logic [7:0] exp_p[3][$];
  logic [7:0] exp_b[3][$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit [7:0] rot8(input bit [7:0] r, input bit dir);
    return dir ? {r[0], r[7:1]} : {r[6:0], r[7]};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_row[d] = '0; m_cnt[d] = 0; m_first[d] = 1'b1; m_err[d] = 1'b0;
      exp_p[d].delete(); exp_b[d].delete();
    end
  endtask

  task automatic model_accept(input bit si, input bit load, input bit [7:0] row,
                              input bit [7:0] seed, input bit last);
    bit [7:0] g, p;
    for (int d = 0; d < 3; d++) begin
      if (m_first[d]) begin m_cnt[d] = 0; m_seed[d] = seed; end
      g = load ? row : rot8(m_row[d], rdir[d]);
      m_row[d] = g;
      m_g[d][m_cnt[d]] = g;
      m_u[d][m_cnt[d]] = si;
      m_cnt[d]++;
      if (last || m_cnt[d] == maxb[d]) begin
        p = m_seed[d];
        for (int j = 0; j < 8; j++)
          for (int k = 0; k < m_cnt[d]; k++) p[j] = p[j] ^ (m_u[d][k] & m_g[d][k][j]);
        exp_p[d].push_back(p);
        exp_b[d].push_back(8'(m_cnt[d]));
        if (!last) m_err[d] = 1'b1;
        m_first[d] = 1'b1;
      end else begin
        m_first[d] = 1'b0;
      end
    end
  endtask

  task automatic sample();
    if (!mon_en) return;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("err%0d", d), er[d], m_err[d]);
      chk($sformatf("in_ready%0d", d), ir[d], ir[0]);
      if (ov[0] && out_ready) begin
        if (exp_p[d].size() == 0) begin
          chk($sformatf("unexpected_word%0d", d), ov[d], 0);
        end else begin
          chk($sformatf("out_valid%0d", d), ov[d], 1);
          chk($sformatf("parity%0d", d), op[d], exp_p[d][0]);
          chk($sformatf("beats%0d", d), ob[d], exp_b[d][0]);
          void'(exp_p[d].pop_front());
          void'(exp_b[d].pop_front());
        end
      end
    end
  endtask

  task automatic align();
    @(posedge clk); #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic beat(input bit si, input bit load, input bit [7:0] row,
                      input bit [7:0] seed, input bit last);
    int n = 0;
    in_valid = 1'b1; in_si = si; in_load = load; in_row = row; in_seed = seed; in_last = last;
    forever begin
      @(negedge clk);
      sample();
      if (ir0) break;
      n++;
      if (n > 100) begin
        errors++;
        $display("FAIL accept_timeout: in_ready stuck at 0 for %0d cycles", n);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "in_ready timeout");
      end
      align();
    end
    model_accept(si, load, row, seed, last);
    align();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    align();
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; in_si = 0; in_load = 0; in_last = 0;
    in_row = '0; in_seed = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Reset values
    @(negedge clk);
    chk("rst_out_valid", ov0, 0);
    chk("rst_parity", op0, 0);
    chk("rst_beats", ob0, 0);
    chk("rst_err", er0, 0);
    chk("rst_in_ready", ir0, 1);
    align();

    // Single-beat frame: A5 ^ 0F
    beat(1, 1, 8'hA5, 8'h0F, 1);
    @(negedge clk);
    chk("t1_valid", ov0, 1);
    chk("t1_parity", op0, 8'hAA);
    chk("t1_beats", ob0, 1);
    align();

    // Rotated rows, left: 01,02,(04),08 -> 0B; seed ignored after first beat
    beat(1, 1, 8'h01, 8'h00, 0);
    beat(1, 0, 8'h00, 8'hFF, 0);
    beat(0, 0, 8'h00, 8'hFF, 0);
    beat(1, 0, 8'h00, 8'hFF, 1);
    @(negedge clk);
    chk("t2_left_parity", op0, 8'h0B);
    chk("t2_left_beats", ob0, 4);
    align();
    // Right rotation: 80,40,(20),10 -> D0
    beat(1, 1, 8'h80, 8'h00, 0);
    beat(1, 0, 8'h00, 8'hFF, 0);
    beat(0, 0, 8'h00, 8'hFF, 0);
    beat(1, 0, 8'h00, 8'hFF, 1);
    @(negedge clk);
    chk("t2_right_parity", op1, 8'hD0);
    chk("t2_right_beats", ob1, 4);
    align();

    // Backpressure with same-cycle refill
    out_ready = 1'b0;
    beat(1, 1, 8'h33, 8'h00, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_hold_ready", ir0, 0);
      chk("t3_hold_valid", ov0, 1);
      chk("t3_hold_parity", op0, 8'h33);
    end
    align();
    out_ready = 1'b1;
    in_valid = 1'b1; in_si = 1; in_load = 1; in_row = 8'h5A; in_seed = 8'h00; in_last = 1;
    @(negedge clk);
    chk("t3_both_in_ready", ir0, 1);
    chk("t3_both_out_valid", ov0, 1);
    align();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_refill_valid", ov0, 1);
    chk("t3_refill_parity", op0, 8'h5A);
    chk("t3_refill_beats", ob0, 1);
    align();

    // Overflow on the MAX_BEATS=4 instance
    beat(1, 1, 8'h01, 8'h10, 0);
    beat(1, 1, 8'h02, 8'h00, 0);
    beat(1, 1, 8'h04, 8'h00, 0);
    beat(1, 1, 8'h08, 8'h00, 0);
    @(negedge clk);
    chk("t4_valid", ov2, 1);
    chk("t4_parity", op2, 8'h1F);
    chk("t4_beats", ob2, 4);
    chk("t4_err", er2, 1);
    chk("t4_big_valid", ov0, 0);
    chk("t4_big_err", er0, 0);
    align();
    beat(1, 1, 8'h80, 8'h03, 0);
    beat(0, 1, 8'h00, 8'hFF, 1);
    @(negedge clk);
    chk("t4_new_frame_parity", op2, 8'h83);
    chk("t4_new_frame_beats", ob2, 2);
    chk("t4_big_parity", op0, 8'h9F);
    chk("t4_big_beats", ob0, 6);
    align();
    repeat (2) align();
    @(negedge clk);
    chk("t4_err_sticky", er2, 1);
    align();
    do_reset();
    @(negedge clk);
    chk("t4_err_cleared", er2, 0);
    align();

    // Reset mid-frame
    beat(1, 1, 8'hFF, 8'h55, 0);
    beat(1, 1, 8'h3C, 8'h00, 0);
    do_reset();
    @(negedge clk);
    chk("t5_rst_valid", ov0, 0);
    chk("t5_rst_parity", op0, 0);
    chk("t5_rst_beats", ob0, 0);
    chk("t5_rst_err", er0, 0);
    chk("t5_rst_ready", ir0, 1);
    align();
    beat(1, 0, 8'hFF, 8'h21, 0);
    beat(1, 1, 8'h0C, 8'h00, 0);
    beat(1, 0, 8'h00, 8'h00, 1);
    @(negedge clk);
    chk("t5_post_parity", op0, 8'h35);
    chk("t5_post_beats", ob0, 3);
    align();

    // Random frames against the model, random backpressure
    do_reset();
    mon_en = 1; rnd_rdy = 1;
    for (int f = 0; f < 1000; f++) begin
      int  len;
      bit  zero;
      bit [7:0] seed;
      len  = $urandom_range(1, 4);
      zero = ($urandom_range(0, 7) == 0);
      seed = 8'($urandom);
      for (int k = 0; k < len; k++) begin
        bit ld, s;
        ld = (k == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        s  = zero ? 1'b0 : 1'($urandom_range(0, 1));
        beat(s, ld, 8'($urandom), (k == 0) ? seed : 8'($urandom), k == len - 1);
      end
    end
    rnd_rdy = 0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      sample();
    end
    for (int d = 0; d < 3; d++) chk($sformatf("drain%0d", d), exp_p[d].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
